// File: rtl/lb_uart_pkg.sv
// Shared UART definitions: widths, FSM encodings and the parity helper.
// Common to the transmitter and receiver; no logic of its own.
// No backpressure (constants and a pure function only).
package lb_uart_pkg;

    localparam int BAUD_W = 20;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    // Parity covers only the bits actually sent; bit 7 is dropped in 7-bit mode.
    function automatic logic calc_parity(input logic [DATA_W-1:0] d,
                                         input logic              bit8,
                                         input logic              odd_n_even);
        logic [DATA_W-1:0] m;
        m = bit8 ? d : {1'b0, d[DATA_W-2:0]};
        return (^m) ^ odd_n_even;
    endfunction

endpackage

// File: rtl/lb_uart_baud_gen.sv
// Reloadable bit-period counter: tick marks the last clock of each bit period.
// Latency: tick is combinational from the count; a period is terminal+1 clocks.
// No backpressure; counter rests at zero while en is low.
module lb_uart_baud_gen
    import lb_uart_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              restart,
    input  logic [BAUD_W-1:0] terminal,
    output logic              tick
);

    logic [BAUD_W-1:0] cnt;

    assign tick = en && (cnt == terminal);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (!en || restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + BAUD_W'(1);
        end
    end

endmodule

// File: rtl/lb_uart_tx_core.sv
// UART transmitter: start bit, 7/8 data bits LSB first, optional parity, one stop bit.
// Latency: tx drops to the start bit on the edge that accepts load.
// Backpressure: tx_rdy low for the whole frame; loads seen while busy are dropped.
module lb_uart_tx_core
    import lb_uart_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [BAUD_W-1:0] baud_value,
    input  logic              bit8,
    input  logic              parity_en,
    input  logic              odd_n_even,
    input  logic              cs,
    input  logic              load,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx,
    output logic              tx_rdy,
    output logic              done
);

    uart_state_t       state, state_nxt;
    logic [BAUD_W-1:0] baud_lat;
    logic              bit8_lat;
    logic              par_en_lat;
    logic              par_bit;
    logic [DATA_W-1:0] shift, shift_nxt;
    logic [2:0]        data_cnt, data_cnt_nxt;
    logic              tx_q, tx_nxt;
    logic              accept;
    logic              tick;
    logic [2:0]        last_data;

    assign tx_rdy    = (state == IDLE);
    assign accept    = cs && load && tx_rdy;
    assign done      = (state == STOP) && tick;
    assign tx        = tx_q;
    assign last_data = bit8_lat ? 3'd7 : 3'd6;

    lb_uart_baud_gen u_baud_gen (
        .clk      (clk),
        .reset    (reset),
        .en       (state != IDLE),
        .restart  (accept),
        .terminal (baud_lat),
        .tick     (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            shift    <= '0;
            data_cnt <= '0;
            tx_q     <= 1'b1;
        end else begin
            state    <= state_nxt;
            shift    <= shift_nxt;
            data_cnt <= data_cnt_nxt;
            tx_q     <= tx_nxt;
        end
    end

    // Frame configuration is frozen at acceptance so input changes mid-frame are harmless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_lat   <= '0;
            bit8_lat   <= 1'b0;
            par_en_lat <= 1'b0;
            par_bit    <= 1'b0;
        end else if (accept) begin
            baud_lat   <= baud_value;
            bit8_lat   <= bit8;
            par_en_lat <= parity_en;
            par_bit    <= calc_parity(data_in, bit8, odd_n_even);
        end
    end

    always_comb begin
        state_nxt    = state;
        shift_nxt    = shift;
        data_cnt_nxt = data_cnt;
        tx_nxt       = tx_q;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (accept) begin
                    state_nxt    = START;
                    tx_nxt       = 1'b0;
                    shift_nxt    = data_in;
                    data_cnt_nxt = '0;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                    tx_nxt    = shift[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (data_cnt == last_data) begin
                        data_cnt_nxt = '0;
                        if (par_en_lat) begin
                            state_nxt = PARITY;
                            tx_nxt    = par_bit;
                        end else begin
                            state_nxt = STOP;
                            tx_nxt    = 1'b1;
                        end
                    end else begin
                        data_cnt_nxt = data_cnt + 3'd1;
                        shift_nxt    = shift >> 1;
                        tx_nxt       = shift[1];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nxt = STOP;
                    tx_nxt    = 1'b1;
                end
            end
            STOP: begin
                if (tick) begin
                    state_nxt = IDLE;
                    tx_nxt    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_lb_uart_tx_core.sv
// Randomised bench for lb_uart_tx_core against a bit-list frame model.
module tb_lb_uart_tx_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] baud_value;
    logic        bit8, parity_en, odd_n_even, cs, load;
    logic [7:0]  data_in;
    logic        tx, tx_rdy, done;

    int vectors     = 0;
    int miscompares = 0;
    bit exp_bits[$];

    always #5 clk = ~clk;

    lb_uart_tx_core dut (
        .clk        (clk),
        .reset      (reset),
        .baud_value (baud_value),
        .bit8       (bit8),
        .parity_en  (parity_en),
        .odd_n_even (odd_n_even),
        .cs         (cs),
        .load       (load),
        .data_in    (data_in),
        .tx         (tx),
        .tx_rdy     (tx_rdy),
        .done       (done)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_check(input string tag);
        chk({tag, "_tx"}, tx, 1'b1);
        chk({tag, "_rdy"}, tx_rdy, 1'b1);
        chk({tag, "_done"}, done, 1'b0);
    endtask

    // Expected line levels, one entry per bit of the frame.
    task automatic build_frame(input logic [7:0] d, input bit b8, input bit pe, input bit odd);
        int ones;
        int n;
        ones = 0;
        n = b8 ? 8 : 7;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            exp_bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe) exp_bits.push_back(1'((ones % 2)) ^ odd);
        exp_bits.push_back(1'b1);
    endtask

    // Called at a negedge with tx_rdy high; returns at the negedge where tx_rdy is high again.
    // mode 0: quiet inputs, 1: random input noise during frame, 2: a 0xA5 load mid-frame.
    task automatic run_frame(input logic [7:0] d, input bit b8, input bit pe, input bit odd,
                             input int baud, input int mode);
        int per;
        int total;
        build_frame(d, b8, pe, odd);
        per   = baud + 1;
        total = exp_bits.size() * per;
        chk("rdy_before", tx_rdy, 1'b1);
        cs = 1'b1; load = 1'b1; data_in = d; bit8 = b8;
        parity_en = pe; odd_n_even = odd; baud_value = 20'(baud);
        for (int k = 1; k <= total; k++) begin
            @(negedge clk);
            chk("tx", tx, exp_bits[(k - 1) / per]);
            chk("rdy_busy", tx_rdy, 1'b0);
            chk("done", done, k == total);
            if (mode == 1) begin
                cs         = 1'($urandom);
                load       = 1'($urandom);
                data_in    = 8'($urandom);
                bit8       = 1'($urandom);
                parity_en  = 1'($urandom);
                odd_n_even = 1'($urandom);
                baud_value = 20'($urandom_range(0, 7));
            end else if (mode == 2 && k == total / 2) begin
                cs = 1'b1; load = 1'b1; data_in = 8'hA5;
            end else begin
                load = 1'b0;
            end
        end
        @(negedge clk);
        chk("rdy_after", tx_rdy, 1'b1);
        chk("tx_after", tx, 1'b1);
        chk("done_after", done, 1'b0);
        load = 1'b0;
        cs   = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rd;
        reset = 1'b1; cs = 1'b0; load = 1'b0; data_in = '0;
        baud_value = '0; bit8 = 1'b0; parity_en = 1'b0; odd_n_even = 1'b0;
        repeat (3) @(negedge clk);
        idle_check("reset");
        reset = 1'b0;
        @(negedge clk);
        idle_check("post_reset");

        run_frame(8'h55, 1'b1, 1'b1, 1'b0, 3, 0);
        run_frame(8'h81, 1'b0, 1'b1, 1'b1, 3, 0);
        run_frame(8'hFF, 1'b1, 1'b0, 1'b0, 0, 0);
        run_frame(8'hFF, 1'b1, 1'b0, 1'b0, 0, 0);
        run_frame(8'h3C, 1'b1, 1'b0, 1'b0, 2, 2);

        cs = 1'b0; load = 1'b1; data_in = 8'h12;
        repeat (5) begin
            @(negedge clk);
            idle_check("cs0");
        end
        load = 1'b0; cs = 1'b1;

        // Interrupt a frame during data bit 3 with an asynchronous reset.
        build_frame(8'hC3, 1'b1, 1'b0, 1'b0);
        cs = 1'b1; load = 1'b1; data_in = 8'hC3; bit8 = 1'b1;
        parity_en = 1'b0; odd_n_even = 1'b0; baud_value = 20'd3;
        @(negedge clk);
        load = 1'b0;
        repeat (17) @(negedge clk);
        chk("pre_rst_tx", tx, exp_bits[4]);
        chk("pre_rst_rdy", tx_rdy, 1'b0);
        #2 reset = 1'b1;
        #1;
        idle_check("rst_async");
        cs = 1'b1; load = 1'b1; data_in = 8'h00;
        @(negedge clk);
        idle_check("rst_hold");
        reset = 1'b0;
        load  = 1'b0;
        run_frame(8'hC3, 1'b1, 1'b0, 1'b0, 3, 0);

        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                idle_check("gap");
            end
            rd = 8'($urandom);
            run_frame(rd, 1'($urandom), 1'($urandom), 1'($urandom),
                      $urandom_range(0, 4), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
